// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared definitions for the serial receiver.
//   - default frame geometry (data bits, clocks per bit)
//   - FSM state encodings, 3-bit constants so legacy code can share them
package serial_rx_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  // True for the states in which a frame is being received.
  function automatic logic in_frame(input logic [2:0] st);
    return (st == ST_START) || (st == ST_DATA) || (st == ST_STOP);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer: free-running bit-period counter for the serial receiver.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   clear      - hold the counter at 0 (receiver not inside a frame)
//   mid        - high while the count sits at CLKS_PER_BIT/2 (sample point)
//   period_end - high on the last cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic mid,
  output logic period_end
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign mid        = (cnt_q == MID_CNT);
  assign period_end = (cnt_q == LAST_CNT);

  // Count k mod CLKS_PER_BIT, where k is the cycle number within the frame.
  // Releasing clear in the start-detect cycle makes the first frame cycle
  // read 1, so mid lands on k = j*CLKS_PER_BIT + CLKS_PER_BIT/2.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || period_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_rx.sv
// serial_rx: start-bit detecting serial receiver, LSB-first, mid-bit sampling.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset
//   in        - synchronised serial line, idle high
//   data_out  - last correctly framed word
//   valid     - one-cycle strobe, data_out updated this cycle
//   frame_err - one-cycle strobe, stop bit sampled low
//   busy      - high while in START/DATA/STOP
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  logic mid;
  // Period boundary is not needed by this FSM; the timer offers it anyway.
  logic period_end_unused;

  // Timer runs only while the next state is inside a frame, so it restarts
  // from 0 on every return to IDLE (false start, good stop, reset).
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (!busy_d),
    .mid        (mid),
    .period_end (period_end_unused)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_WAIT_IDLE: if (in) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!in) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: if (mid) state_d = in ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (mid) begin
          // LSB-first: new bit enters at the top and walks down.
          for (int i = 0; i < DATA_W - 1; i++) shift_d[i] = shift_q[i+1];
          shift_d[DATA_W-1] = in;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid) begin
          if (in) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            // IDLE before the stop bit ends: a start bit may follow at once.
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
    busy_d = in_frame(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed + randomized bench for serial_rx. Expected behaviour
// is derived frame by frame from the line protocol: frame cycle k carries
// bit k/C, busy spans cycles 1..STROBE-1, strobes appear at STROBE.
module tb_serial_rx;

  localparam int W      = 8;
  localparam int C      = 4;
  localparam int FRAME  = (W + 2) * C;
  localparam int STROBE = (W + 1) * C + C / 2 + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         line;
  logic [W-1:0] data_out;
  logic         valid, frame_err, busy;

  serial_rx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (line),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           cyc_n = 0;
  int           last_vcyc = -1;
  int           prev_vcyc = -1;
  logic [W-1:0] exp_data;
  logic [W-1:0] s_data;
  logic         s_valid, s_err, s_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the line at v; outputs sampled mid-cycle.
  task automatic step(input logic v);
    line = v;
    @(negedge clk);
    s_data  = data_out;
    s_valid = valid;
    s_err   = frame_err;
    s_busy  = busy;
    if (valid === 1'b1) begin
      prev_vcyc = last_vcyc;
      last_vcyc = cyc_n;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [W-1:0] d, input logic stop_ok, input int k);
    int j;
    j = k / C;
    if (j == 0)      return 1'b0;
    else if (j <= W) return d[j-1];
    else             return stop_ok;
  endfunction

  task automatic quiet(input string tag);
    chk({tag, "_busy"},  s_busy,  0);
    chk({tag, "_valid"}, s_valid, 0);
    chk({tag, "_ferr"},  s_err,   0);
  endtask

  task automatic send(input logic [W-1:0] d, input logic stop_ok);
    for (int k = 0; k < FRAME; k++) begin
      step(frame_bit(d, stop_ok, k));
      chk("busy",      s_busy,  32'((k >= 1) && (k < STROBE)));
      chk("valid",     s_valid, 32'((k == STROBE) && stop_ok));
      chk("frame_err", s_err,   32'((k == STROBE) && !stop_ok));
      if (k == STROBE && stop_ok) exp_data = d;
      if (k == 0 || k == STROBE) chk("data_out", s_data, exp_data);
    end
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rok;
    int           gap;

    // Reset with the line idle.
    reset = 1'b1;
    line  = 1'b1;
    @(posedge clk); #1;
    step(1'b1);
    step(1'b1);
    exp_data = '0;
    chk("rst_data", s_data, 0);
    quiet("rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin step(1'b1); quiet("pre_idle"); end

    send(8'hA5, 1'b1);

    // One-cycle glitch: false start, busy for cycles 1-2 only.
    step(1'b0); quiet("glitch0");
    step(1'b1); chk("glitch_busy1", s_busy, 1); chk("glitch_v1", s_valid, 0);
    step(1'b1); chk("glitch_busy2", s_busy, 1); chk("glitch_v2", s_valid, 0);
    step(1'b1); quiet("glitch3");
    step(1'b1); quiet("glitch4");
    send(8'h3C, 1'b1);

    // Framing error, then line held low: no start may be detected.
    send(8'hFF, 1'b0);
    for (int i = 0; i < 20; i++) begin step(1'b0); quiet("low_hold"); end
    step(1'b1); quiet("relax");
    send(8'h01, 1'b1);

    // Reset released with the line low.
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    exp_data = '0;
    chk("rstlow_data", s_data, 0);
    quiet("rstlow");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1'b0); quiet("rstlow_hold"); chk("rstlow_d", s_data, 0); end
    step(1'b1); quiet("rstlow_hi");
    step(1'b1); quiet("rstlow_hi");
    send(8'h77, 1'b1);

    // Reset mid-frame; the sender abandons the frame as well.
    for (int k = 0; k < 20; k++) begin
      step(frame_bit(8'h12, 1'b1, k));
      chk("abort_busy", s_busy, 32'(k >= 1));
    end
    reset = 1'b1;
    step(frame_bit(8'h12, 1'b1, 20));
    reset = 1'b0;
    step(1'b1);
    exp_data = '0;
    chk("abort_data", s_data, 0);
    quiet("abort");
    for (int i = 0; i < 6; i++) begin step(1'b1); quiet("abort_idle"); end
    send(8'h5A, 1'b1);
    step(1'b1); quiet("gap");

    // Back-to-back frames with no idle after the stop bit.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    chk("b2b_spacing", 32'(last_vcyc - prev_vcyc), 32'(FRAME));
    step(1'b1); quiet("b2b_tail");

    // Random frames, gaps and occasional framing errors.
    for (int n = 0; n < 16; n++) begin
      rd  = W'($urandom_range(0, (1 << W) - 1));
      rok = ($urandom_range(0, 3) != 0);
      gap = rok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      send(rd, rok);
      for (int g = 0; g < gap; g++) begin step(1'b1); quiet("rnd_gap"); end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
Asynchronous-style serial receiver that consumes the synchronised single-bit line produced by the two-stage input buffer, one stage downstream of it.
- Detects a start bit, samples each bit at mid-period and assembles LSB-first data words.
- Presents each word with a one-cycle valid strobe; flags framing errors.
- Used by the top level wherever an external serial line enters the design.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles per bit period (>=2); mid-sample offset is CLKS_PER_BIT/2 (integer division)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
in  input  1  serial line, already synchronised upstream; idle level 1
data_out  output  DATA_W  last correctly framed word
valid  output  1  one-cycle strobe: data_out updated this cycle
frame_err  output  1  one-cycle strobe: stop bit sampled as 0
busy  output  1  high while a frame is being received (START/DATA/STOP)

Behaviour:
- Reset (sync, priority over everything):
  - state=WAIT_IDLE; data_out=0, valid=0, frame_err=0, busy=0.
  - Bit counter, cycle counter and shift register cleared.
  - Partial frame discarded.
- States: WAIT_IDLE, IDLE, START, DATA, STOP.
- WAIT_IDLE: stay until in==1 is sampled, then go to IDLE. Prevents a line held low after reset or after a framing error from being taken as a start bit.
- Frame timing: the cycle in which IDLE samples in==0 is relative cycle 0 (cycle 0 of the start bit).
  - Bit j (0=start, 1..DATA_W=data, DATA_W+1=stop) is sampled at relative cycle j*CLKS_PER_BIT + CLKS_PER_BIT/2.
- IDLE: in==0 -> START, cycle counter=1.
- START: at the mid-sample, in==1 -> false start, back to IDLE with no strobe; in==0 -> DATA.
- DATA: at each mid-sample, shift in the bit LSB-first; after DATA_W samples -> STOP.
- STOP, at the mid-sample:
  - in==1 -> data_out <= assembled word, valid=1 for exactly one cycle, then IDLE.
  - in==0 -> frame_err=1 for exactly one cycle, data_out unchanged, then WAIT_IDLE.
- Latency: valid/frame_err are visible at relative cycle (DATA_W+1)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1. Defaults: sample at cycle 38, strobe visible at cycle 39.
- Back-to-back frames: IDLE is re-entered before the stop bit ends, so a start bit immediately following the stop bit (no extra idle) is accepted.
- valid and frame_err are never high together; both are registered.
- busy = 1 exactly in START/DATA/STOP; registered with state.
- Counters: cycle counter width $clog2(CLKS_PER_BIT)+1; bit counter width $clog2(DATA_W+1); no wrap occurs within a legal frame.

Decomposition:
- Shared header (e.g. serial_defs.vh):
  - state encodings (3-bit localparams: WAIT_IDLE=0, IDLE=1, START=2, DATA=3, STOP=4);
  - default DATA_W and CLKS_PER_BIT.
- One sub-module is natural: bit_timer.
  - Inputs: clk, reset, clear.
  - Outputs: mid (pulse at CLKS_PER_BIT/2 of each period), end (period boundary).
  - The FSM and shift register stay in serial_rx.

Test Plan (CLKS_PER_BIT=4, DATA_W=8, each bit held 4 cycles):
- Line high 5 cycles, then frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> valid high for exactly one cycle at relative cycle 39, data_out=8'hA5, frame_err=0, busy low from cycle 39.
- in low 1 cycle then high (glitch) -> busy high cycles 1-2, no strobe, busy 0 at cycle 3. Following frame 0x3C -> data_out=8'h3C.
- Framing error: frame 0xFF with stop bit 0, line then held low 20 cycles, then high, then frame 0x01:
  - frame_err one cycle at relative cycle 39; data_out stays 8'h3C;
  - no start detected while the line is low;
  - then valid with data_out=8'h01.
- Reset released with in=0 held 10 cycles, then high 2 cycles, then frame 0x77 -> no activity while low; data_out=8'h77 afterwards.
- reset pulsed at relative cycle 20 of frame 0x12 -> next cycle all outputs 0, no strobe for the aborted frame. Subsequent frame 0x5A -> data_out=8'h5A.
- Frames 0x00 and 0xFF back-to-back, no gap after stop bit -> two valid strobes 40 cycles apart, data_out 8'h00 then 8'hFF.
